// File: rtl/swap_pkg.sv
// Shared encodings for the swap controller / datapath pair.
package swap_pkg;

    localparam logic [1:0] SEL_IDLE    = 2'd0;
    localparam logic [1:0] SEL_SAVE    = 2'd1;
    localparam logic [1:0] SEL_MOVE    = 2'd2;
    localparam logic [1:0] SEL_RESTORE = 2'd3;

    typedef enum logic [1:0] {
        CK_IDLE = 2'd0,
        CK_S1   = 2'd1,
        CK_S2   = 2'd2
    } ck_state_e;

    // True when the controller drives a real step (write with a non-idle select).
    function automatic logic is_step(input logic w, input logic [1:0] sel, input logic [1:0] want);
        return w && (sel == want);
    endfunction

endpackage

// File: rtl/swap_seq_checker.sv
// Observes the sel/w/ld stream and raises a sticky err on any illegal sequence.
// Purely passive: it never gates the datapath writes.
module swap_seq_checker
    import swap_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] sel,
    input  logic       w,
    input  logic       ld,
    output logic       err
);

    ck_state_e state_q, state_d;
    logic      viol;
    logic      err_q, err_d;

    always_comb begin
        state_d = CK_IDLE;
        viol    = 1'b0;

        unique case (state_q)
            CK_IDLE: begin
                if (!w && (sel == SEL_IDLE)) begin
                    state_d = CK_IDLE;
                end else if (is_step(w, sel, SEL_SAVE)) begin
                    state_d = CK_S1;
                end else begin
                    viol = 1'b1;
                end
            end
            CK_S1: begin
                if (is_step(w, sel, SEL_MOVE)) begin
                    state_d = CK_S2;
                end else begin
                    viol = 1'b1;
                end
            end
            CK_S2: begin
                if (is_step(w, sel, SEL_RESTORE)) begin
                    state_d = CK_IDLE;
                end else begin
                    viol = 1'b1;
                end
            end
            default: viol = 1'b1;
        endcase

        // A load colliding with a step is illegal regardless of step legality.
        if (ld && w) begin
            viol = 1'b1;
        end

        // Resynchronise: a save seen during a violation still starts a new sequence.
        if (viol) begin
            state_d = is_step(w, sel, SEL_SAVE) ? CK_S1 : CK_IDLE;
        end

        err_d = err_q | viol;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CK_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/swap_datapath.sv
// A/B/T register bank executing save/move/restore steps, with load port,
// done pulse and wrapping swap counter. Define SWAP_SEQ_CHECK_EN to add the protocol checker.
module swap_datapath
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       sel,
    input  logic             w,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_a,
    input  logic [WIDTH-1:0] ld_b,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             done,
    output logic [CNT_W-1:0] swap_cnt,
    output logic             err
);

    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] a_d, b_d, t_d;
    logic [CNT_W-1:0] cnt_d;
    logic             done_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        t_d    = t_q;
        cnt_d  = swap_cnt;
        done_d = 1'b0;

        if (w) begin
            // Steps win over loads; sel=0 with w=1 writes nothing.
            case (sel)
                SEL_SAVE:    t_d = a_q;
                SEL_MOVE:    a_d = b_q;
                SEL_RESTORE: begin
                    b_d    = t_q;
                    cnt_d  = swap_cnt + CNT_W'(1);
                    done_d = 1'b1;
                end
                default: ;
            endcase
        end else if (ld) begin
            a_d = ld_a;
            b_d = ld_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            swap_cnt <= '0;
            done     <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            swap_cnt <= cnt_d;
            done     <= done_d;
        end
    end

`ifdef SWAP_SEQ_CHECK_EN
    swap_seq_checker u_checker (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (sel),
        .w       (w),
        .ld      (ld),
        .err     (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_swap_datapath.sv
// Directed + randomized bench for swap_datapath against a behavioural model.
module tb_swap_datapath;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic [1:0]       sel;
    logic             w;
    logic             ld;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] ld_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             done;
    logic [CNT_W-1:0] swap_cnt;
    logic             err;

    swap_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel      (sel),
        .w        (w),
        .ld       (ld),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .a_q      (a_q),
        .b_q      (b_q),
        .done     (done),
        .swap_cnt (swap_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: operand values, counter as an integer, and the index
    // of the step the protocol expects next (0 = save or idle, 1 = move, 2 = restore).
    int  m_a, m_b, m_t, m_cnt, m_phase;
    bit  m_err, m_done;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err();
`ifdef SWAP_SEQ_CHECK_EN
        return int'(m_err);
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_t = 0; m_cnt = 0; m_phase = 0; m_err = 0; m_done = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a_q"}, int'(a_q), m_a);
        chk({tag, ".b_q"}, int'(b_q), m_b);
        chk({tag, ".done"}, int'(done), int'(m_done));
        chk({tag, ".swap_cnt"}, int'(swap_cnt), m_cnt);
        chk({tag, ".err"}, int'(err), exp_err());
    endtask

    // One clock cycle of controller activity, model update, and full output check.
    task automatic cyc(input string tag, input bit l, input int la, input int lb,
                       input bit ww, input int s);
        bit legal;
        @(negedge clk);
        ld = l; ld_a = WIDTH'(la); ld_b = WIDTH'(lb); w = ww; sel = 2'(s);
        @(posedge clk);
        m_done = 0;
        if (ww) begin
            if (s == 1) m_t = m_a;
            if (s == 2) m_a = m_b;
            if (s == 3) begin
                m_b = m_t;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_done = 1;
            end
        end else if (l) begin
            m_a = la % (1 << WIDTH);
            m_b = lb % (1 << WIDTH);
        end
        legal = !(l && ww) &&
                ((!ww && s == 0 && m_phase == 0) || (ww && s == m_phase + 1));
        if (legal) m_phase = ww ? (m_phase + 1) % 3 : 0;
        else       m_phase = (ww && s == 1) ? 1 : 0;
        if (!legal) m_err = 1;
        #1;
        check_all(tag);
    endtask

    task automatic swap3(input string tag);
        cyc(tag, 0, 0, 0, 1, 1);
        cyc(tag, 0, 0, 0, 1, 2);
        cyc(tag, 0, 0, 0, 1, 3);
    endtask

    // Assert reset mid-cycle with the given step on the bus; checks both the
    // asynchronous clear and that nothing moves across the following edge.
    task automatic async_reset(input string tag, input bit ww, input int s);
        @(negedge clk);
        reset_n = 1'b0; w = ww; sel = 2'(s); ld = 1'b0;
        #1;
        model_clear();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        reset_n = 1'b1; w = 1'b0; sel = 2'd0;
    endtask

    int done_pulses;
    int orig_a, orig_b;

    initial begin
        reset_n = 1'b0; sel = 2'd0; w = 1'b0; ld = 1'b0; ld_a = '0; ld_b = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all("por");
        reset_n = 1'b1;

        // Reset clears loaded operands immediately.
        cyc("rst_load", 1, 'h3C, 'hA5, 0, 0);
        async_reset("rst", 0, 0);

        // Legal swap; done follows restore for one cycle only.
        cyc("sw_load", 1, 'h12, 'h34, 0, 0);
        swap3("sw");
        chk("sw.a_final", int'(a_q), 'h34);
        chk("sw.b_final", int'(b_q), 'h12);
        chk("sw.done_hi", int'(done), 1);
        cyc("sw_idle", 0, 0, 0, 0, 0);
        chk("sw.done_lo", int'(done), 0);
        chk("sw.cnt", int'(swap_cnt), 1);

        // Load asserted during the move step is ignored.
        cyc("blk_load", 1, 'h5A, 'hC3, 0, 0);
        cyc("blk", 0, 0, 0, 1, 1);
        cyc("blk", 1, 'hFF, 'hFF, 1, 2);
        cyc("blk", 0, 0, 0, 1, 3);
        chk("blk.a", int'(a_q), 'hC3);
        chk("blk.b", int'(b_q), 'h5A);
        cyc("blk_idle", 0, 0, 0, 0, 0);

        // Out-of-order: restore straight after save.
        cyc("ooo_load", 1, 'h77, 'h11, 0, 0);
        cyc("ooo", 0, 0, 0, 1, 1);
        cyc("ooo", 0, 0, 0, 1, 3);
        chk("ooo.b", int'(b_q), 'h77);
        cyc("ooo_idle", 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) swap3("ooo_sticky");

        // 16 directly back-to-back swaps wrap the counter and restore positions.
        cyc("wrap_load", 1, 'h9E, 'h4B, 0, 0);
        orig_a = int'(a_q);
        orig_b = int'(b_q);
        async_reset("wrap_rst", 0, 0);
        cyc("wrap_load2", 1, orig_a, orig_b, 0, 0);
        done_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc("wrap", 0, 0, 0, 1, 1);
            if (done) done_pulses++;
            cyc("wrap", 0, 0, 0, 1, 2);
            if (done) done_pulses++;
            cyc("wrap", 0, 0, 0, 1, 3);
            if (done) done_pulses++;
        end
        cyc("wrap_idle", 0, 0, 0, 0, 0);
        if (done) done_pulses++;
        chk("wrap.pulses", done_pulses, 16);
        chk("wrap.cnt", int'(swap_cnt), 0);
        chk("wrap.a", int'(a_q), orig_a);
        chk("wrap.b", int'(b_q), orig_b);
        chk("wrap.err", int'(err), 0);

        // Random traffic: mostly legal swaps mixed with loads and stray steps.
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            if (kind < 3) begin
                cyc("rnd_load", 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0);
                swap3("rnd_swap");
            end else if (kind == 3) begin
                cyc("rnd_idle", 0, 0, 0, 0, 0);
            end else begin
                cyc("rnd_any", bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
            end
        end

        // Reset during the move step loses the swap; a fresh swap works cleanly.
        cyc("mid_load", 1, 'h21, 'h43, 0, 0);
        cyc("mid", 0, 0, 0, 1, 1);
        async_reset("mid_rst", 1, 2);
        chk("mid.done", int'(done), 0);
        cyc("fresh_load", 1, 'h66, 'h99, 0, 0);
        swap3("fresh");
        cyc("fresh_idle", 0, 0, 0, 0, 0);
        chk("fresh.a", int'(a_q), 'h99);
        chk("fresh.b", int'(b_q), 'h66);
        chk("fresh.cnt", int'(swap_cnt), 1);
        chk("fresh.err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
